// File: rtl/sparq_cmd_scheduler.sv
// SPARQ command scheduler: stages host operands, launches the six datapath
// engines (plus PE array reset) under busy / buffer-hazard ordering and
// publishes progress on the status port.
//
//   state  | meaning
//   IDLE   | accepting commands; staging writes land here
//   WAIT   | launch latched, holding off until the target's hazards clear
//   LAUNCH | one-cycle start pulse; a new command may be accepted
module sparq_cmd_scheduler #(
  parameter int NUM_ENG = 6,
  parameter int FSIZE   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*FSIZE+8:0]         cmd_in,
  output logic                       cmd_ready,
  output logic [NUM_ENG-1:0]         eng_start,
  output logic [NUM_ENG*FSIZE-1:0]   eng_param,
  input  logic [NUM_ENG-1:0]         eng_done,
  output logic                       pe_reset,
  output logic [8*FSIZE-1:0]         status
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, LAUNCH = 2'd2} state_t;

  // Target 6 is the PE-reset pseudo-engine; it only guards against GEMM.
  localparam logic [2:0] TGT_PE = 3'd6;

  state_t             state, state_n;
  logic [FSIZE-1:0]   p [NUM_ENG];
  logic [2:0]         tgt;
  logic [NUM_ENG-1:0] busy;
  logic [FSIZE-1:0]   launch_cnt;
  logic [FSIZE-1:0]   done_cnt;
  logic               err_cmd;
  logic               err_done;

  logic               cmd_valid;
  logic [7:0]         code;
  logic [FSIZE-1:0]   data0, data1;
  logic               accept;
  logic [7:0]         grp_off;
  logic [1:0]         suffix;
  logic [2:0]         cmd_tgt;
  logic               cmd_stage, cmd_pe, cmd_bad;
  logic               go_wait;
  logic               launch_ok;
  logic [NUM_ENG-1:0] done_ok;
  logic [FSIZE-1:0]   done_pop;

  assign cmd_valid = cmd_in[2*FSIZE+8];
  assign code      = cmd_in[2*FSIZE+7:2*FSIZE];
  assign data0     = cmd_in[2*FSIZE-1:FSIZE];
  assign data1     = cmd_in[FSIZE-1:0];
  assign cmd_ready = (state != WAIT);
  assign accept    = cmd_valid && cmd_ready;
  assign done_ok   = eng_done & busy;

  // Decode the command code into engine target and staging suffix.
  always_comb begin
    grp_off   = code - 8'd5;
    suffix    = 2'd0;
    cmd_tgt   = 3'd0;
    cmd_stage = 1'b0;
    cmd_pe    = 1'b0;
    cmd_bad   = 1'b0;
    if (code == 8'd1) begin
      cmd_pe  = 1'b1;
      cmd_tgt = TGT_PE;
    end else if (code >= 8'd2 && code <= 8'd4) begin
      cmd_stage = 1'b1;
      suffix    = 2'(code - 8'd2);
      cmd_tgt   = 3'd0;
    end else if (code >= 8'd5 && code <= 8'd19) begin
      cmd_stage = 1'b1;
      suffix    = 2'(grp_off % 8'd3);
      cmd_tgt   = 3'(grp_off / 8'd3 + 8'd1);
    end else begin
      cmd_bad = 1'b1;
    end
    go_wait = accept && (cmd_pe || (cmd_stage && suffix == 2'd2));
  end

  // Hazard check for the latched target, always against registered busy.
  always_comb begin
    launch_ok = 1'b0;
    if (tgt == 3'd0)
      launch_ok = ~|busy[4:0];
    else if (tgt == TGT_PE)
      launch_ok = ~busy[0];
    else if (tgt < 3'(NUM_ENG))
      launch_ok = ~busy[tgt] && ~busy[0];
  end

  // Count accepted done pulses in this cycle.
  always_comb begin
    done_pop = '0;
    for (int i = 0; i < NUM_ENG; i++)
      done_pop = done_pop + FSIZE'(done_ok[i]);
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go_wait) state_n = WAIT;
      WAIT:    if (launch_ok) state_n = LAUNCH;
      LAUNCH:  state_n = go_wait ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand staging and launch-target latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENG; i++) p[i] <= '0;
      tgt <= 3'd0;
    end else if (accept) begin
      if (cmd_stage) begin
        case (suffix)
          2'd0:    begin p[0] <= data0; p[1] <= data1; end
          2'd1:    begin p[2] <= data0; p[3] <= data1; end
          default: begin p[4] <= data0; p[5] <= data1; end
        endcase
      end
      if (go_wait) tgt <= cmd_tgt;
    end
  end

  // Busy tracking, progress counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      launch_cnt <= '0;
      done_cnt   <= '0;
      err_cmd    <= 1'b0;
      err_done   <= 1'b0;
    end else begin
      busy     <= (busy & ~done_ok) | eng_start;
      done_cnt <= done_cnt + done_pop;
      if (state == LAUNCH) launch_cnt <= launch_cnt + 1'b1;
      if (accept && cmd_bad) err_cmd <= 1'b1;
      if (|(eng_done & ~busy)) err_done <= 1'b1;
    end
  end

  // Launch pulses and output packing.
  always_comb begin
    eng_start = '0;
    pe_reset  = 1'b0;
    eng_param = '0;
    if (state == LAUNCH) begin
      if (tgt == TGT_PE)               pe_reset = 1'b1;
      else if (tgt < 3'(NUM_ENG))      eng_start = NUM_ENG'(1) << tgt;
    end
    for (int i = 0; i < NUM_ENG; i++)
      eng_param[i*FSIZE +: FSIZE] = p[i];
  end

  // Busy shows the engine being launched in the same cycle as its start pulse.
  assign status = {{(4*FSIZE){1'b0}},
                   {(FSIZE-4){1'b0}}, err_done, err_cmd, state,
                   done_cnt,
                   launch_cnt,
                   {(FSIZE-NUM_ENG){1'b0}}, busy | eng_start};

endmodule

// File: tb/tb_sparq_cmd_scheduler.sv
// Directed bench for sparq_cmd_scheduler with hand-computed expectations.
module tb_sparq_cmd_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic [72:0]  cmd_in;
  logic         cmd_ready;
  logic [5:0]   eng_start;
  logic [191:0] eng_param;
  logic [5:0]   eng_done;
  logic         pe_reset;
  logic [255:0] status;

  int vectors = 0;
  int miscompares = 0;

  sparq_cmd_scheduler dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_ready(cmd_ready),
    .eng_start(eng_start), .eng_param(eng_param), .eng_done(eng_done),
    .pe_reset(pe_reset), .status(status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] d0, input logic [31:0] d1);
    cmd_in = {1'b1, c, d0, d1};
    step();
    cmd_in = '0;
  endtask

  task automatic pulse_done(input logic [5:0] d);
    eng_done = d;
    step();
    eng_done = '0;
  endtask

  logic [7:0] codes [4];
  logic [5:0] starts [4];

  initial begin
    rst = 1'b1; cmd_in = '0; eng_done = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_start", eng_start, 0);
    chk("reset_param", eng_param, 0);
    chk("reset_pe", pe_reset, 0);
    chk("reset_status", status, 0);

    // A_LOAD staging and launch
    send(8'd5, 32'h1000, 32'h40);
    chk("stage0_param", eng_param[63:0], {32'h40, 32'h1000});
    send(8'd6, 32'd1, 32'd2);
    send(8'd7, 32'd3, 32'd4);
    chk("a_wait_ready", cmd_ready, 0);
    chk("a_wait_fsm", status[97:96], 1);
    chk("a_wait_nostart", eng_start, 0);
    step();
    chk("a_start", eng_start, 6'b000010);
    chk("a_param", eng_param, {32'd4, 32'd3, 32'd2, 32'd1, 32'h40, 32'h1000});
    chk("a_state0", status[31:0], 32'h2);
    chk("a_launch_ready", cmd_ready, 1);
    step();
    chk("a_once", eng_start, 0);
    chk("a_state1", status[63:32], 1);
    chk("a_busy_held", status[31:0], 32'h2);

    // GEMM waits for A_LOAD to drain
    send(8'd4, 32'd7, 32'd8);
    for (int i = 0; i < 3; i++) step();
    chk("gemm_stall_ready", cmd_ready, 0);
    chk("gemm_stall_fsm", status[97:96], 1);
    chk("gemm_stall_start", eng_start, 0);
    pulse_done(6'b000010);
    chk("gemm_m1_busy", status[31:0], 0);
    chk("gemm_m1_nostart", eng_start, 0);
    chk("gemm_m1_state2", status[95:64], 1);
    step();
    chk("gemm_m2_start", eng_start, 6'b000001);
    chk("gemm_m2_state0", status[31:0], 32'h1);

    // C_STORE stalls behind GEMM
    send(8'd19, 32'd9, 32'd10);
    chk("cst_wait_ready", cmd_ready, 0);
    step();
    chk("cst_stall", eng_start, 0);
    pulse_done(6'b000001);
    chk("cst_m1_state2", status[95:64], 2);
    chk("cst_m1_nostart", eng_start, 0);
    step();
    chk("cst_m2_start", eng_start, 6'b100000);
    chk("cst_m2_state0", status[31:0], 32'h20);
    step();
    chk("cst_state1", status[63:32], 3);

    // illegal command and spurious done
    send(8'h2A, 32'd0, 32'd0);
    chk("bad_ready", cmd_ready, 1);
    chk("bad_errcmd", status[98], 1);
    chk("bad_nostart", eng_start, 0);
    pulse_done(6'b001000);
    chk("spur_errdone", status[99], 1);
    chk("spur_state2", status[95:64], 2);
    pulse_done(6'b100000);
    chk("cst_done_state0", status[31:0], 0);
    chk("cst_done_state2", status[95:64], 3);

    // four loads, then simultaneous done
    codes[0] = 8'd13; starts[0] = 6'b001000;
    codes[1] = 8'd16; starts[1] = 6'b010000;
    codes[2] = 8'd10; starts[2] = 6'b000100;
    codes[3] = 8'd7;  starts[3] = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      send(codes[i], 32'd0, 32'd0);
      step();
      chk("multi_start", eng_start, starts[i]);
      step();
    end
    chk("multi_state0", status[31:0], 32'h1E);
    chk("multi_state1", status[63:32], 7);
    pulse_done(6'b011110);
    chk("multi_done_state0", status[31:0], 0);
    chk("multi_done_state2", status[95:64], 7);

    // PE reset
    send(8'd1, 32'd0, 32'd0);
    step();
    chk("pe_pulse", pe_reset, 1);
    chk("pe_nostart", eng_start, 0);
    step();
    chk("pe_once", pe_reset, 0);
    chk("pe_state1", status[63:32], 8);
    chk("pe_fsm", status[97:96], 0);

    // reset during WAIT discards the pending GEMM launch
    send(8'd4, 32'd1, 32'd1);
    chk("rst_wait_fsm", status[97:96], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_nostart", eng_start, 0);
    chk("rst_status", status, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_param", eng_param, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_quiet", {pe_reset, eng_start}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
